// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset controller for the datapath flip-flop banks.
//
// The asynchronous master reset asserts every rst_out bit at once. Its release
// is synchronized to clock, and the stages are then released one at a time in
// index order, each held for HOLD_CYCLES cycles. A soft request re-runs the
// whole sequence without touching the external reset.
//
// Optional feature: define STAGE_ACK_EN to add the stage_ack port. Each stage
// except the last then waits for its acknowledge (bounded by ACK_TIMEOUT)
// before the next stage's hold begins. A missing ack sets the sticky
// timeout_err flag and parks the block in an error state.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high master reset
//   soft_req    in   synchronous soft-reset request
//   stage_ack   in   per-stage acknowledge (STAGE_ACK_EN only)
//   rst_out     out  active-high reset per stage, bit 0 released first
//   busy        out  sequence in progress
//   done        out  all stages released
//   stage       out  index of the stage currently held
//   timeout_err out  sticky acknowledge-timeout flag (0 without STAGE_ACK_EN)
module reset_sequencer #(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 64,
    localparam int unsigned STAGE_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               soft_req,
`ifdef STAGE_ACK_EN
    input  logic [NUM_OUT-1:0] stage_ack,
`endif
    output logic [NUM_OUT-1:0] rst_out,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic               timeout_err
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_OUT - 1);
`ifdef STAGE_ACK_EN
    localparam logic [CNT_W-1:0]   ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        StWaitSync,
        StHold,
        StDone
`ifdef STAGE_ACK_EN
        ,
        StWaitAck,
        StError
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_OUT-1:0]   rst_out_q, rst_out_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 rst_sync;

    // Last flop of the deassertion synchronizer.
    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b0};
        state_d   = state_q;
        rst_out_d = rst_out_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        // A soft request wins over anything else due on the same edge.
        if (!rst_sync && soft_req) begin
            state_d   = StHold;
            rst_out_d = '1;
            stage_d   = '0;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                StWaitSync: begin
                    if (!rst_sync) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_d[stage_q] = 1'b0;
                        cnt_d              = '0;
                        if (stage_q == STAGE_LAST) begin
                            state_d = StDone;
                        end else begin
                            stage_d = stage_q + STAGE_W'(1);
`ifdef STAGE_ACK_EN
                            state_d = StWaitAck;
`else
                            state_d = StHold;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef STAGE_ACK_EN
                // stage_q already points at the next stage; the ack belongs
                // to the one just released.
                StWaitAck: begin
                    if (stage_ack[stage_q - STAGE_W'(1)]) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else if (cnt_q == ACK_LAST) begin
                        timeout_d = 1'b1;
                        rst_out_d = '1;
                        cnt_d     = '0;
                        state_d   = StError;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StError: begin
                    state_d = StError;
                end
`endif
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StWaitSync;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            state_q   <= StWaitSync;
            rst_out_q <= '1;
            stage_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            rst_out_q <= rst_out_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StWaitSync: busy = 1'b1;
            StHold:     busy = 1'b1;
`ifdef STAGE_ACK_EN
            StWaitAck:  busy = 1'b1;
`endif
            StDone:     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign rst_out = rst_out_q;
    assign stage   = stage_q;
`ifdef STAGE_ACK_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
